ftdi_fifo_device: RTL and testbench

Cycle-level, synthesizable model of the FT245 device side of the asynchronous FIFO interface. It presents RXF#/TXE#, answers RD# by driving the shared data bus, and latches bytes on WR#. Internal FIFOs connect to valid/accept streams. It sits opposite the FPGA-side FT245 master in loopback benches and in FPGA-to-FPGA links where one end emulates the FTDI part.

---
 rtl/ftdi_fifo_device.sv | 210 +++++++++++++++++++++
 tb/tb_ftdi_fifo_device.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ftdi_fifo_device.sv
// FT245 device-side emulation: presents RXF#/TXE#, serves RD# from an RX FIFO
// fed by a valid/accept stream, and captures WR# bytes into a TX FIFO drained
// by a second stream.
module ftdi_fifo_device #(
  parameter int DEPTH            = 16,
  parameter int ADDR_W           = 4,
  parameter int RD_ACCESS_CYCLES = 1,
  parameter int PRECHARGE_CYCLES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  output logic       ftdi_rxf_o,
  output logic       ftdi_txe_o,
  input  logic       ftdi_rd_i,
  input  logic       ftdi_wr_i,
  inout  wire  [7:0] ftdi_d_io,
  input  logic [7:0] in_data_i,
  input  logic       in_valid_i,
  output logic       in_accept_o,
  output logic [7:0] out_data_o,
  output logic       out_valid_o,
  input  logic       out_accept_i,
  output logic [2:0] err_o
);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]      ACC_LOAD = 4'(RD_ACCESS_CYCLES);
  localparam logic [3:0]      PRE_LOAD = 4'(PRECHARGE_CYCLES);

  typedef enum logic [1:0] {R_IDLE, R_ACCESS, R_DATA, R_PRE} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_HOLD, W_PRE} w_state_t;

  logic              rd_ms_q, rd_sync_q, rd_prev_q;
  logic              wr_ms_q, wr_sync_q, wr_prev_q;
  logic [7:0]        d_ms_q, d_q;
  logic [1:0]        warm_q, warm_d;
  r_state_t          r_state_q, r_state_d;
  w_state_t          w_state_q, w_state_d;
  logic [3:0]        r_cnt_q, r_cnt_d, w_cnt_q, w_cnt_d;
  logic [ADDR_W:0]   rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic [ADDR_W-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [ADDR_W-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [7:0]        rx_mem_q [DEPTH];
  logic [7:0]        tx_mem_q [DEPTH];
  logic [2:0]        err_q, err_d;
  logic              rxf_q, rxf_d, txe_q, txe_d, drv_q, drv_d;
  logic              rd_fall, rd_rise, wr_fall, wr_rise;
  logic              rx_push, rx_pop, tx_push, tx_pop, rx_full, tx_full;

  assign rd_fall = ~rd_sync_q & rd_prev_q;
  assign rd_rise = rd_sync_q & ~rd_prev_q;
  assign wr_fall = ~wr_sync_q & wr_prev_q;
  assign wr_rise = wr_sync_q & ~wr_prev_q;

  assign rx_full     = (rx_cnt_q == FULL_CNT);
  assign tx_full     = (tx_cnt_q == FULL_CNT);
  assign in_accept_o = ~rx_full;
  assign rx_push     = in_valid_i & ~rx_full;
  assign out_valid_o = (tx_cnt_q != '0);
  assign tx_pop      = out_valid_o & out_accept_i;
  assign out_data_o  = out_valid_o ? tx_mem_q[tx_rd_ptr_q] : 8'h00;

  assign ftdi_rxf_o = rxf_q;
  assign ftdi_txe_o = txe_q;
  assign err_o      = err_q;
  assign ftdi_d_io  = drv_q ? rx_mem_q[rx_rd_ptr_q] : 8'bz;

  // Read and write strobe FSMs plus the sticky error flags.
  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d   = r_cnt_q;
    w_state_d = w_state_q;
    w_cnt_d   = w_cnt_q;
    rx_pop    = 1'b0;
    tx_push   = 1'b0;
    err_d     = err_q;
    // Synchronizers reset to 0, so both strobes look low until the pipeline
    // has refilled; the contention flag waits for that to avoid a false hit.
    warm_d    = (warm_q == 2'd2) ? warm_q : warm_q + 2'd1;
    if (warm_q == 2'd2 && !rd_sync_q && !wr_sync_q) err_d[2] = 1'b1;

    case (r_state_q)
      R_IDLE: begin
        if (rd_fall) begin
          if (rx_cnt_q == '0) begin
            err_d[0] = 1'b1;
          end else if (RD_ACCESS_CYCLES == 0) begin
            r_state_d = R_DATA;
          end else begin
            r_state_d = R_ACCESS;
            r_cnt_d   = ACC_LOAD;
          end
        end
      end
      R_ACCESS: begin
        if (rd_rise) begin
          rx_pop    = 1'b1;
          r_state_d = R_PRE;
          r_cnt_d   = PRE_LOAD;
        end else if (r_cnt_q <= 4'd1) begin
          r_state_d = R_DATA;
        end else begin
          r_cnt_d = r_cnt_q - 4'd1;
        end
      end
      R_DATA: begin
        if (rd_rise) begin
          rx_pop    = 1'b1;
          r_state_d = R_PRE;
          r_cnt_d   = PRE_LOAD;
        end
      end
      default: begin
        if (r_cnt_q <= 4'd1) r_state_d = R_IDLE;
        else                 r_cnt_d   = r_cnt_q - 4'd1;
      end
    endcase

    case (w_state_q)
      W_IDLE: begin
        if (wr_fall) begin
          if (tx_full) err_d[1] = 1'b1;
          else         tx_push  = 1'b1;
          w_state_d = W_HOLD;
        end
      end
      W_HOLD: begin
        if (wr_rise) begin
          w_state_d = W_PRE;
          w_cnt_d   = PRE_LOAD;
        end
      end
      default: begin
        if (w_cnt_q <= 4'd1) w_state_d = W_IDLE;
        else                 w_cnt_d   = w_cnt_q - 4'd1;
      end
    endcase
  end

  // FIFO pointers/counts and the registered strobe-side outputs.
  always_comb begin
    rx_wr_ptr_d = rx_push ? rx_wr_ptr_q + 1'b1 : rx_wr_ptr_q;
    rx_rd_ptr_d = rx_pop  ? rx_rd_ptr_q + 1'b1 : rx_rd_ptr_q;
    tx_wr_ptr_d = tx_push ? tx_wr_ptr_q + 1'b1 : tx_wr_ptr_q;
    tx_rd_ptr_d = tx_pop  ? tx_rd_ptr_q + 1'b1 : tx_rd_ptr_q;
    rx_cnt_d    = rx_cnt_q + {{ADDR_W{1'b0}}, rx_push} - {{ADDR_W{1'b0}}, rx_pop};
    tx_cnt_d    = tx_cnt_q + {{ADDR_W{1'b0}}, tx_push} - {{ADDR_W{1'b0}}, tx_pop};
    rxf_d       = (r_state_d == R_IDLE) ? (rx_cnt_d == '0) : (r_state_d == R_PRE);
    txe_d       = (w_state_d == W_IDLE) ? (tx_cnt_d == FULL_CNT) : 1'b1;
    drv_d       = (r_state_d == R_DATA);
  end

  // All control state, with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ms_q     <= 1'b0;
      rd_sync_q   <= 1'b0;
      rd_prev_q   <= 1'b0;
      wr_ms_q     <= 1'b0;
      wr_sync_q   <= 1'b0;
      wr_prev_q   <= 1'b0;
      d_ms_q      <= 8'h00;
      d_q         <= 8'h00;
      warm_q      <= 2'd0;
      r_state_q   <= R_IDLE;
      w_state_q   <= W_IDLE;
      r_cnt_q     <= 4'd0;
      w_cnt_q     <= 4'd0;
      rx_cnt_q    <= '0;
      tx_cnt_q    <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      err_q       <= 3'b000;
      rxf_q       <= 1'b1;
      txe_q       <= 1'b1;
      drv_q       <= 1'b0;
    end else begin
      rd_ms_q     <= ftdi_rd_i;
      rd_sync_q   <= rd_ms_q;
      rd_prev_q   <= rd_sync_q;
      wr_ms_q     <= ftdi_wr_i;
      wr_sync_q   <= wr_ms_q;
      wr_prev_q   <= wr_sync_q;
      d_ms_q      <= ftdi_d_io;
      d_q         <= d_ms_q;
      warm_q      <= warm_d;
      r_state_q   <= r_state_d;
      w_state_q   <= w_state_d;
      r_cnt_q     <= r_cnt_d;
      w_cnt_q     <= w_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      err_q       <= err_d;
      rxf_q       <= rxf_d;
      txe_q       <= txe_d;
      drv_q       <= drv_d;
    end
  end

  // FIFO storage; contents need no reset since the counts gate visibility.
  always_ff @(posedge clk_i) begin
    if (rx_push) rx_mem_q[rx_wr_ptr_q] <= in_data_i;
    if (tx_push) tx_mem_q[tx_wr_ptr_q] <= d_q;
  end
endmodule

// File: tb/tb_ftdi_fifo_device.sv
// Bench for ftdi_fifo_device: table of operations with flag expectations,
// byte scoreboards for both FIFO directions, plus hand-written corner cases.
module tb_ftdi_fifo_device;
  localparam int DEPTH = 16;

  typedef enum {OP_PUSH, OP_READ, OP_WRITE, OP_DRAIN} op_e;
  typedef struct {
    op_e        op;
    logic [7:0] data;
    int         exp_pre;   // read only: rxf high length, 0 = stays high
    logic       exp_rxf;
    logic       exp_txe;
    logic       exp_ov;
    logic [7:0] exp_od;
    logic [2:0] exp_err;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, rd_n, wr_n, in_valid, out_accept, tb_d_en;
  logic [7:0] in_data, tb_d;
  logic       rxf, txe, in_accept, out_valid;
  logic [7:0] out_data;
  logic [2:0] err;
  tri1  [7:0] bus;

  assign bus = tb_d_en ? tb_d : 8'bz;
  always #5 clk = ~clk;

  ftdi_fifo_device dut (
    .clk_i(clk), .rst_i(rst), .ftdi_rxf_o(rxf), .ftdi_txe_o(txe),
    .ftdi_rd_i(rd_n), .ftdi_wr_i(wr_n), .ftdi_d_io(bus),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_accept_o(in_accept),
    .out_data_o(out_data), .out_valid_o(out_valid), .out_accept_i(out_accept),
    .err_o(err)
  );

  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] rx_sb[$];
  logic [7:0] tx_sb[$];
  int         rx_model = 0;
  int         tx_model = 0;
  vec_t       tbl[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(op_e op, logic [7:0] d, int pre, logic rf, logic te,
                              logic ov, logic [7:0] od, logic [2:0] e);
    vec_t v;
    v.op = op; v.data = d; v.exp_pre = pre; v.exp_rxf = rf; v.exp_txe = te;
    v.exp_ov = ov; v.exp_od = od; v.exp_err = e;
    return v;
  endfunction

  task automatic push_byte(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    chk("in_accept", in_accept, rx_model != DEPTH);
    if (rx_model != DEPTH) begin
      rx_sb.push_back(d);
      rx_model++;
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic master_read(input bit has_data, input int exp_pre);
    int n;
    logic [7:0] exp;
    chk("in_accept_pre_read", in_accept, rx_model != DEPTH);
    rd_n = 1'b0;
    repeat (6) tick();
    if (has_data) begin
      if (rx_sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL rd_sb: bus 0x%0h but no byte was expected", bus);
      end else begin
        exp = rx_sb.pop_front();
        rx_model--;
        chk("rd_bus", bus, exp);
      end
    end else begin
      chk("rd_bus_z", bus, 8'hFF);
    end
    repeat (2) tick();
    rd_n = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (rxf) n++;
      else if (n > 0) break;
    end
    if (exp_pre > 0) chk("rxf_precharge_len", n, exp_pre);
    else             chk("rxf_stays_high", rxf, 1'b1);
  endtask

  task automatic master_write(input logic [7:0] d);
    chk("txe_pre_write", txe, tx_model == DEPTH);
    tb_d    = d;
    tb_d_en = 1'b1;
    wr_n    = 1'b0;
    repeat (6) tick();
    wr_n = 1'b1;
    tick();
    tb_d_en = 1'b0;
    repeat (8) tick();
    if (tx_model < DEPTH) begin
      tx_sb.push_back(d);
      tx_model++;
    end
  endtask

  task automatic drain();
    bit done = 1'b0;
    out_accept = 1'b1;
    for (int i = 0; i < 3 * DEPTH && !done; i++) begin
      if (!out_valid) begin
        done = 1'b1;
      end else begin
        if (tx_sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL drain_extra: got 0x%0h, expected no byte", out_data);
        end else begin
          chk("drain_data", out_data, tx_sb.pop_front());
        end
        if (tx_model > 0) tx_model--;
        tick();
      end
    end
    out_accept = 1'b0;
    chk("drain_done", done, 1'b1);
    chk("drain_sb_empty", tx_sb.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = mk(OP_PUSH,  8'hA5, 0, 1'b0, 1'b0, 1'b0, 8'h00, 3'b000);
    tbl[1] = mk(OP_PUSH,  8'h3C, 0, 1'b0, 1'b0, 1'b0, 8'h00, 3'b000);
    tbl[2] = mk(OP_READ,  8'h00, 2, 1'b0, 1'b0, 1'b0, 8'h00, 3'b000);
    tbl[3] = mk(OP_READ,  8'h00, 0, 1'b1, 1'b0, 1'b0, 8'h00, 3'b000);
    tbl[4] = mk(OP_WRITE, 8'h11, 0, 1'b1, 1'b0, 1'b1, 8'h11, 3'b000);
    tbl[5] = mk(OP_WRITE, 8'h12, 0, 1'b1, 1'b0, 1'b1, 8'h11, 3'b000);
    tbl[6] = mk(OP_WRITE, 8'h13, 0, 1'b1, 1'b0, 1'b1, 8'h11, 3'b000);
    tbl[7] = mk(OP_WRITE, 8'h14, 0, 1'b1, 1'b0, 1'b1, 8'h11, 3'b000);
    tbl[8] = mk(OP_DRAIN, 8'h00, 0, 1'b1, 1'b0, 1'b0, 8'h00, 3'b000);

    rst = 1'b1; rd_n = 1'b1; wr_n = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    out_accept = 1'b0; tb_d_en = 1'b0; tb_d = 8'h00;

    // reset state
    tick();
    chk("rst_rxf", rxf, 1'b1);
    chk("rst_txe", txe, 1'b1);
    chk("rst_bus_z", bus, 8'hFF);
    chk("rst_in_accept", in_accept, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_err", err, 3'b000);
    repeat (2) tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("idle_rxf", rxf, 1'b1);
    chk("idle_txe", txe, 1'b0);
    chk("idle_err", err, 3'b000);

    // table-driven basic read/write traffic
    for (int i = 0; i < 9; i++) begin
      case (tbl[i].op)
        OP_PUSH:  push_byte(tbl[i].data);
        OP_READ:  master_read(1'b1, tbl[i].exp_pre);
        OP_WRITE: master_write(tbl[i].data);
        default:  drain();
      endcase
      chk("tbl_rxf", rxf, tbl[i].exp_rxf);
      chk("tbl_txe", txe, tbl[i].exp_txe);
      chk("tbl_out_valid", out_valid, tbl[i].exp_ov);
      chk("tbl_out_data", out_data, tbl[i].exp_od);
      chk("tbl_err", err, tbl[i].exp_err);
    end

    // TX full, overflow write
    for (int i = 0; i < DEPTH; i++) master_write(8'(i));
    chk("txe_full", txe, 1'b1);
    repeat (4) tick();
    chk("txe_full_hold", txe, 1'b1);
    master_write(8'hEE);
    chk("err_wr_full", err, 3'b010);
    drain();
    chk("tx_empty_valid", out_valid, 1'b0);

    // RD# while RX empty
    master_read(1'b0, 0);
    chk("err_rd_empty", err, 3'b011);

    // RX fill/drain with pointer wrap
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < DEPTH; i++) push_byte(8'(r * DEPTH + i));
      in_valid = 1'b1;
      in_data  = 8'hEE;
      chk("in_accept_full", in_accept, 1'b0);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < DEPTH; i++) master_read(1'b1, (i == DEPTH - 1) ? 0 : 2);
      chk("rx_drained_accept", in_accept, 1'b1);
    end

    // both strobes low
    rd_n = 1'b0; wr_n = 1'b0;
    repeat (6) tick();
    chk("err_both_low", err, 3'b111);
    rd_n = 1'b1; wr_n = 1'b1;
    repeat (10) tick();

    // reset while in R_DATA with RD# held low
    rx_sb.delete(); tx_sb.delete(); rx_model = 0; tx_model = 0;
    push_byte(8'h77);
    rd_n = 1'b0;
    repeat (6) tick();
    chk("bus_before_reset", bus, 8'h77);
    rst = 1'b1;
    tick();
    chk("mid_rst_bus_z", bus, 8'hFF);
    chk("mid_rst_rxf", rxf, 1'b1);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_err", err, 3'b000);
    rst = 1'b0;
    rx_sb.delete(); rx_model = 0;
    tick();
    push_byte(8'h5C);
    repeat (10) tick();
    chk("no_spurious_rxf", rxf, 1'b0);
    chk("no_spurious_bus", bus, 8'hFF);
    chk("no_spurious_err", err, 3'b000);
    rd_n = 1'b1;
    repeat (4) tick();
    master_read(1'b1, 0);
    chk("post_reset_err", err, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
